// File: rtl/cpu_pkg.sv
// Shared definitions for the CPU output path: transmitter state encoding and default frame sizing.
package cpu_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } tx_state_e;

  localparam int unsigned DEFAULT_WIDTH        = 8;
  localparam int unsigned DEFAULT_CLKS_PER_BIT = 16;

  // Counter width for a modulus of n, never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/tx_bit_timer.sv
// Bit-period timer: counts clock cycles within one serial bit and flags the last one.
module tx_bit_timer
  import cpu_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  output logic bit_done
);

  localparam int unsigned     CNT_W = cnt_width(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      r_cnt <= '0;
    end else if (r_cnt == LAST) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign bit_done = (r_cnt == LAST);

endmodule

// File: rtl/reg_serial_tx.sv
// Parallel-to-serial transmitter: start bit, WIDTH data bits LSB-first, stop bit.
module reg_serial_tx
  import cpu_pkg::*;
#(
  parameter int unsigned WIDTH        = DEFAULT_WIDTH,
  parameter int unsigned CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             tx_valid,
  input  logic [WIDTH-1:0] tx_data,
  output logic             tx_ready,
  output logic             tx_serial,
  output logic             busy
);

  localparam int unsigned      IDX_W    = cnt_width(WIDTH);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(WIDTH - 1);

  tx_state_e        r_state;
  logic [WIDTH-1:0] r_shift;
  logic [IDX_W-1:0] r_bit_idx;
  logic             r_tx_serial;
  logic             r_tx_ready;
  logic             r_busy;

  logic             w_accept;
  logic             w_bit_done;
  logic [WIDTH-1:0] w_shift_next;

  assign w_accept     = (r_state == ST_IDLE) && tx_valid;
  assign w_shift_next = r_shift >> 1;

  // Clearing on accept aligns the first timer period with the first start-bit cycle.
  tx_bit_timer #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_bit_timer (
    .clk      (clk),
    .reset    (reset),
    .clear    (w_accept),
    .bit_done (w_bit_done)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_shift     <= '0;
      r_bit_idx   <= '0;
      r_tx_serial <= 1'b1;
      r_tx_ready  <= 1'b1;
      r_busy      <= 1'b0;
    end else begin
      unique case (r_state)
        ST_IDLE: begin
          if (tx_valid) begin
            r_state     <= ST_START;
            r_shift     <= tx_data;
            r_bit_idx   <= '0;
            r_tx_serial <= 1'b0;
            r_tx_ready  <= 1'b0;
            r_busy      <= 1'b1;
          end
        end
        ST_START: begin
          if (w_bit_done) begin
            r_state     <= ST_DATA;
            r_tx_serial <= r_shift[0];
          end
        end
        ST_DATA: begin
          if (w_bit_done) begin
            if (r_bit_idx == IDX_LAST) begin
              r_state     <= ST_STOP;
              r_tx_serial <= 1'b1;
            end else begin
              // Output is registered, so present the next bit as it shifts in.
              r_shift     <= w_shift_next;
              r_bit_idx   <= r_bit_idx + 1'b1;
              r_tx_serial <= w_shift_next[0];
            end
          end
        end
        ST_STOP: begin
          if (w_bit_done) begin
            r_state    <= ST_IDLE;
            r_tx_ready <= 1'b1;
            r_busy     <= 1'b0;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign tx_serial = r_tx_serial;
  assign tx_ready  = r_tx_ready;
  assign busy      = r_busy;

endmodule
